// File: rtl/md_ctrl_pkg.sv
// Shared op codes, default latencies and FSM encodings for the HI/LO
// multiply/divide sequencer and the hazard unit.
package md_ctrl_pkg;

  localparam logic [2:0] MD_OP_NONE  = 3'd0;
  localparam logic [2:0] MD_OP_MULT  = 3'd1;
  localparam logic [2:0] MD_OP_MULTU = 3'd2;
  localparam logic [2:0] MD_OP_DIV   = 3'd3;
  localparam logic [2:0] MD_OP_DIVU  = 3'd4;
  localparam logic [2:0] MD_OP_MTHI  = 3'd5;
  localparam logic [2:0] MD_OP_MTLO  = 3'd6;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  localparam logic [0:0] MD_ST_IDLE = 1'b0;
  localparam logic [0:0] MD_ST_RUN  = 1'b1;

  function automatic int md_cnt_width(int a, int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Loadable down-counter modelling mult/div latency.
// done pulses while the count sits at 1.
module md_latency_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer for the E stage.
// MD_DIV0_HOLD_EN: divide-by-zero keeps the prior HI/LO.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        stop,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [0:0]    state_q, state_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [63:0]   res_q, res_d;
  logic          go;
  logic          load;
  logic          done;
  logic [CW-1:0] load_val;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   quot, rem;

  assign busy = (state_q == MD_ST_RUN);
  assign go   = start & ~stop & ~busy;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    prod_s = {{32{rs_val[31]}}, rs_val}
           * {{32{rt_val[31]}}, rt_val};
    prod_u = {32'b0, rs_val} * {32'b0, rt_val};
    if (rt_val == 32'b0) begin
`ifdef MD_DIV0_HOLD_EN
      // HI/LO cannot change while busy, so this holds them.
      quot = lo_q;
      rem  = hi_q;
`else
      quot = 32'hFFFF_FFFF;
      rem  = rs_val;
`endif
    end else if (op == MD_OP_DIV) begin
      quot = $signed(rs_val) / $signed(rt_val);
      rem  = $signed(rs_val) % $signed(rt_val);
    end else begin
      quot = rs_val / rt_val;
      rem  = rs_val % rt_val;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    load     = 1'b0;
    load_val = '0;
    if (go) begin
      case (op)
        MD_OP_MULT: begin
          res_d    = prod_s;
          load     = 1'b1;
          load_val = CW'(MULT_CYCLES);
          state_d  = MD_ST_RUN;
        end
        MD_OP_MULTU: begin
          res_d    = prod_u;
          load     = 1'b1;
          load_val = CW'(MULT_CYCLES);
          state_d  = MD_ST_RUN;
        end
        MD_OP_DIV, MD_OP_DIVU: begin
          res_d    = {rem, quot};
          load     = 1'b1;
          load_val = CW'(DIV_CYCLES);
          state_d  = MD_ST_RUN;
        end
        MD_OP_MTHI: hi_d = rs_val;
        MD_OP_MTLO: lo_d = rs_val;
        default: ;
      endcase
    end
    if (busy && done) begin
      hi_d    = res_q[63:32];
      lo_d    = res_q[31:0];
      state_d = MD_ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  md_latency_counter #(
    .W(CW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: latency, results, MT*, stop and reset.
// Build with MD_DIV0_HOLD_EN to check the hold variant.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        stop;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  md_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .stop   (stop),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch op, then wait for busy to drop; optionally pulse a
  // stray start or a stop at busy-cycle index inj/stp.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input int cyc, input logic [31:0] eh,
                        input logic [31:0] el,
                        input int inj, input int stp);
    int n;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    step();
    start = 1'b0;
    op = MD_OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 50) begin
      start = (n == inj);
      stop  = (n == stp);
      step();
      n++;
    end
    start = 1'b0;
    stop  = 1'b0;
    check({tag, "_cycles"}, 64'(n), 64'(cyc));
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = MD_OP_NONE; stop = 1'b0;
    rs_val = '0; rt_val = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    run_op("mult", MD_OP_MULT, 32'hFFFF_FFFD, 32'd5, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, -1, -1);
    run_op("multu", MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5,
           32'h0000_0001, 32'hFFFF_FFFE, -1, -1);
    run_op("div", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1);
`ifdef MD_DIV0_HOLD_EN
    run_op("divu0", MD_OP_DIVU, 32'd7, 32'd0, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1);
`else
    run_op("divu0", MD_OP_DIVU, 32'd7, 32'd0, 10,
           32'h0000_0007, 32'hFFFF_FFFF, -1, -1);
`endif

    start = 1'b1; op = MD_OP_MTHI; rs_val = 32'h1234_5678;
    step();
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_busy", 64'(busy), 64'd0);
    op = MD_OP_MTLO; rs_val = 32'h9ABC_DEF0;
    step();
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtlo_hi", 64'(hi), 64'h1234_5678);
    check("mtlo_busy", 64'(busy), 64'd0);

    start = 1'b1; stop = 1'b1; op = MD_OP_MULT;
    rs_val = 32'd3; rt_val = 32'd3;
    step();
    check("stop_busy", 64'(busy), 64'd0);
    op = MD_OP_MTHI;
    step();
    start = 1'b0; stop = 1'b0;
    check("stop_mthi_hi", 64'(hi), 64'h1234_5678);
    check("stop_lo", 64'(lo), 64'h9ABC_DEF0);
    check("stop_busy2", 64'(busy), 64'd0);

    run_op("inj", MD_OP_MULTU, 32'd3, 32'd4, 5,
           32'd0, 32'd12, 1, -1);
    step();
    check("inj_after_busy", 64'(busy), 64'd0);

    start = 1'b1; op = MD_OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("rdiv_busy_mid", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rdiv_busy", 64'(busy), 64'd0);
    check("rdiv_hi", 64'(hi), 64'd0);
    check("rdiv_lo", 64'(lo), 64'd0);
    run_op("post_rst", MD_OP_MULT, 32'd6, 32'd7, 5,
           32'd0, 32'd42, -1, 2);
    step();
    check("post_rst_hold", 64'(lo), 64'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
